// File: rtl/mb_tx_pkg.sv
// Shared constants and types for the mainband transmit serializer.
// The valid framing pattern is indexed by the 3-bit UI counter within a chunk.
package mb_tx_pkg;

  localparam int UI_PER_CHUNK = 8;
  localparam logic [7:0] VALID_PATTERN = 8'b0000_1111;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Chunk counter width; a single-chunk flit still needs a 1-bit counter.
  function automatic int chunk_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/mb_flit_fifo.sv
// Whole-flit FIFO with registered occupancy count and a combinational head read.
// Handshake: a flit is written on a rising edge where push && ready; ready depends only
// on the registered count, so a same-cycle pop never lets a full FIFO accept.
module mb_flit_fifo #(
  parameter  int FLIT_W = 512,
  parameter  int DEPTH  = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic              ready,
  output logic [CW-1:0]     count
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_acc;
  logic              pop_acc;

  assign ready    = (count != CW'(DEPTH));
  assign push_acc = push && ready;
  assign pop_acc  = pop && (count != '0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mb_tx_serializer.sv
// Mainband transmit serializer: buffers flits and shifts each one out across NUM_LANES
// pins, one bit per lane per UI, with valid framing and optional lane reversal.
module mb_tx_serializer
  import mb_tx_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int FLIT_BYTES = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [FLIT_BYTES-1:0][7:0]        flit_i,
  input  logic                              tx_en_i,
  input  logic                              lane_rev_i,
  output logic [NUM_LANES-1:0]              data_pins_o,
  output logic                              valid_pin_o,
  output logic                              busy_o,
  output logic                              flit_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

  localparam int CHUNKS = FLIT_BYTES / NUM_LANES;
  localparam int CHW    = chunk_width(CHUNKS);
  localparam int BW     = (FLIT_BYTES > 1) ? $clog2(FLIT_BYTES) : 1;
  localparam int FLIT_W = FLIT_BYTES * 8;
  localparam logic [CHW-1:0] LAST_CHUNK = CHW'(CHUNKS - 1);
  localparam logic [2:0]     LAST_UI    = 3'(UI_PER_CHUNK - 1);

  typedef logic [FLIT_BYTES-1:0][7:0] flit_t;

  tx_state_e            state;
  logic [2:0]           ui_ctr;
  logic [CHW-1:0]       chunk_ctr;
  flit_t                work;
  logic                 rev;

  logic [FLIT_W-1:0]    head;
  flit_t                head_flit;
  logic                 start;
  logic                 last_ui;
  logic                 pop;
  logic                 advance;

  flit_t                src;
  logic                 src_rev;
  logic [2:0]           nxt_ui;
  logic [CHW-1:0]       nxt_chunk;
  logic [NUM_LANES-1:0] nxt_pins;
  logic                 nxt_last;
  logic [BW-1:0]        byte_idx;

  mb_flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid_i),
    .push_data (flit_i),
    .pop       (pop),
    .head      (head),
    .ready     (in_ready_o),
    .count     (fifo_count_o)
  );

  assign head_flit = head;
  assign start     = (fifo_count_o != '0) && tx_en_i;
  assign last_ui   = (state == TX_SEND) && (ui_ctr == LAST_UI) && (chunk_ctr == LAST_CHUNK);
  assign pop       = start && ((state == TX_IDLE) || last_ui);
  assign advance   = pop || ((state == TX_SEND) && !last_ui);

  // Next UI to put on the pins: either UI0 of the head flit or the following UI of
  // the working flit. Outputs are registered, so this is computed one cycle ahead.
  always_comb begin
    src       = work;
    src_rev   = rev;
    nxt_ui    = ui_ctr + 3'd1;
    nxt_chunk = chunk_ctr;
    if ((ui_ctr == LAST_UI) && (chunk_ctr != LAST_CHUNK)) begin
      nxt_chunk = chunk_ctr + 1'b1;
    end
    if (pop) begin
      src       = head_flit;
      src_rev   = lane_rev_i;
      nxt_ui    = '0;
      nxt_chunk = '0;
    end
    nxt_pins = '0;
    byte_idx = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      byte_idx    = BW'(int'(nxt_chunk) * NUM_LANES + (src_rev ? (NUM_LANES - 1 - l) : l));
      nxt_pins[l] = src[byte_idx][nxt_ui];
    end
    nxt_last = (nxt_ui == LAST_UI) && (nxt_chunk == LAST_CHUNK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= TX_IDLE;
      ui_ctr      <= '0;
      chunk_ctr   <= '0;
      work        <= '0;
      rev         <= 1'b0;
      data_pins_o <= '0;
      valid_pin_o <= 1'b0;
      busy_o      <= 1'b0;
      flit_done_o <= 1'b0;
    end else if (advance) begin
      state       <= TX_SEND;
      ui_ctr      <= nxt_ui;
      chunk_ctr   <= nxt_chunk;
      data_pins_o <= nxt_pins;
      valid_pin_o <= VALID_PATTERN[nxt_ui];
      busy_o      <= 1'b1;
      flit_done_o <= nxt_last;
      if (pop) begin
        work <= head_flit;
        rev  <= lane_rev_i;
      end
    end else begin
      state       <= TX_IDLE;
      ui_ctr      <= '0;
      chunk_ctr   <= '0;
      data_pins_o <= '0;
      valid_pin_o <= 1'b0;
      busy_o      <= 1'b0;
      flit_done_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mb_tx_serializer.sv
// Directed bench: a 16-lane and a 32-lane serializer share one stimulus stream, each
// tracked by a flit-queue model checked every cycle, plus hand-computed pin checks.
module tb_mb_tx_serializer;

  localparam int FB    = 64;
  localparam int DEPTH = 4;

  typedef logic [FB-1:0][7:0] flit_t;

  logic  clk;
  logic  reset_n;
  logic  in_valid;
  logic  tx_en;
  logic  lane_rev;
  flit_t flit;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : lane_g
    localparam int NL  = (g == 0) ? 16 : 32;
    localparam int UPF = (FB / NL) * 8;

    logic          in_ready;
    logic [NL-1:0] data_pins;
    logic          valid_pin;
    logic          busy;
    logic          flit_done;
    logic [2:0]    fifo_count;

    mb_tx_serializer #(
      .NUM_LANES  (NL),
      .FLIT_BYTES (FB),
      .FIFO_DEPTH (DEPTH)
    ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .flit_i       (flit),
      .tx_en_i      (tx_en),
      .lane_rev_i   (lane_rev),
      .data_pins_o  (data_pins),
      .valid_pin_o  (valid_pin),
      .busy_o       (busy),
      .flit_done_o  (flit_done),
      .fifo_count_o (fifo_count)
    );

    // Model: queue of accepted flits, plus the flit on the wire and its UI index.
    flit_t         exp_q[$];
    flit_t         cur = '0;
    logic          cur_rev = 1'b0;
    int            u = 0;
    bit            active = 1'b0;
    int            pre_sz;
    logic [NL-1:0] e_pins;
    logic [5:0]    bi;
    logic [2:0]    bb;

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        exp_q.delete();
        active = 1'b0;
        u = 0;
      end else begin
        pre_sz = exp_q.size();
        if (active && u < UPF - 1) begin
          u = u + 1;
        end else if (pre_sz != 0 && tx_en) begin
          cur     = exp_q.pop_front();
          cur_rev = lane_rev;
          u       = 0;
          active  = 1'b1;
        end else begin
          active = 1'b0;
        end
        if (in_valid && pre_sz != DEPTH) exp_q.push_back(flit);
      end
    end

    always @(negedge clk) begin
      e_pins = '0;
      if (active) begin
        for (int l = 0; l < NL; l++) begin
          bi = 6'((u / 8) * NL + (cur_rev ? (NL - 1 - l) : l));
          bb = 3'(u % 8);
          e_pins[l] = cur[bi][bb];
        end
      end
      check($sformatf("lanes%0d data_pins", NL), 64'(data_pins), 64'(e_pins));
      check($sformatf("lanes%0d valid_pin", NL), 64'(valid_pin), 64'(active && (u % 8) < 4));
      check($sformatf("lanes%0d busy", NL), 64'(busy), 64'(active));
      check($sformatf("lanes%0d flit_done", NL), 64'(flit_done), 64'(active && u == UPF - 1));
      check($sformatf("lanes%0d fifo_count", NL), 64'(fifo_count), 64'(exp_q.size()));
      check($sformatf("lanes%0d in_ready", NL), 64'(in_ready), 64'(exp_q.size() != DEPTH));
    end
  end

  function automatic flit_t ramp(input int mul, input int add);
    flit_t f;
    for (int k = 0; k < FB; k++) f[k] = 8'(k * mul + add);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input flit_t f);
    in_valid = 1'b1;
    flit     = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 600 && !idle; i++) begin
      tick();
      idle = !lane_g[0].active && lane_g[0].exp_q.size() == 0 &&
             !lane_g[1].active && lane_g[1].exp_q.size() == 0;
    end
    if (!idle) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got still busy after 600 cycles, expected idle");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  l0_8;
    logic [31:0] vv;
    logic [15:0] l0_16;
    logic [15:0] l31_16;
    int done_at, done_n, busy_n;
    int busy1_n, done1_n, run0, max0, run1, max1;
    flit_t f;

    reset_n  = 1'b1;
    in_valid = 1'b0;
    tx_en    = 1'b0;
    lane_rev = 1'b0;
    flit     = '0;
    #1 reset_n = 1'b0;
    repeat (2) tick();
    check("reset busy", 64'(lane_g[0].busy), 64'd0);
    check("reset in_ready", 64'(lane_g[0].in_ready), 64'd1);
    check("reset fifo_count", 64'(lane_g[0].fifo_count), 64'd0);
    check("reset data_pins", 64'(lane_g[1].data_pins), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single flit on 16 lanes: byte k = k, byte 0 = A5.
    tx_en = 1'b1;
    f = ramp(1, 0);
    f[0] = 8'hA5;
    push_flit(f);
    l0_8 = '0; vv = '0; done_at = -1; done_n = 0; busy_n = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i < 8) l0_8 = {lane_g[0].data_pins[0], l0_8[7:1]};
      vv = {lane_g[0].valid_pin, vv[31:1]};
      if (lane_g[0].flit_done) begin done_at = i; done_n++; end
      if (lane_g[0].busy) busy_n++;
    end
    check("single lane0 bits", 64'(l0_8), 64'hA5);
    check("single valid pattern", 64'(vv), 64'h0F0F0F0F);
    check("single done UI", 64'(done_at), 64'd31);
    check("single done pulses", 64'(done_n), 64'd1);
    check("single busy cycles", 64'(busy_n), 64'd32);
    tick();
    check("single busy after", 64'(lane_g[0].busy), 64'd0);
    wait_idle();

    // Three flits back to back.
    busy_n = 0; done_n = 0; busy1_n = 0; done1_n = 0;
    run0 = 0; max0 = 0; run1 = 0; max1 = 0;
    for (int c = 0; c < 140; c++) begin
      in_valid = (c < 3);
      flit     = ramp(3, 17 * c + 1);
      tick();
      if (lane_g[0].busy) begin busy_n++; run0++; end else run0 = 0;
      if (lane_g[1].busy) begin busy1_n++; run1++; end else run1 = 0;
      if (run0 > max0) max0 = run0;
      if (run1 > max1) max1 = run1;
      if (lane_g[0].flit_done) done_n++;
      if (lane_g[1].flit_done) done1_n++;
    end
    check("b2b busy16 cycles", 64'(busy_n), 64'd96);
    check("b2b busy16 run", 64'(max0), 64'd96);
    check("b2b done16 pulses", 64'(done_n), 64'd3);
    check("b2b busy32 run", 64'(max1), 64'd48);
    check("b2b done32 pulses", 64'(done1_n), 64'd3);
    check("b2b busy32 cycles", 64'(busy1_n), 64'd48);
    wait_idle();

    // Transmit disabled: five pushes, four land.
    tx_en = 1'b0;
    for (int c = 0; c < 5; c++) push_flit(ramp(5, 40 + c));
    check("full16 count", 64'(lane_g[0].fifo_count), 64'd4);
    check("full16 in_ready", 64'(lane_g[0].in_ready), 64'd0);
    check("full32 count", 64'(lane_g[1].fifo_count), 64'd4);
    check("full idle busy", 64'(lane_g[0].busy), 64'd0);
    tx_en = 1'b1;
    tick();
    check("enable busy", 64'(lane_g[0].busy), 64'd1);
    check("enable count", 64'(lane_g[0].fifo_count), 64'd3);
    wait_idle();

    // Lane reversal on 32 lanes, toggled mid-flit.
    lane_rev = 1'b1;
    push_flit(ramp(1, 0));
    l0_16 = '0; l31_16 = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      l0_16  = {lane_g[1].data_pins[0], l0_16[15:1]};
      l31_16 = {lane_g[1].data_pins[31], l31_16[15:1]};
      if (i == 3) lane_rev = 1'b0;
    end
    check("rev lane0 bytes", 64'(l0_16), 64'h3F1F);
    check("rev lane31 bytes", 64'(l31_16), 64'h2000);
    push_flit(ramp(7, 3));
    wait_idle();

    // Reset at UI 10 with a second flit queued.
    push_flit(ramp(11, 2));
    push_flit(ramp(13, 9));
    repeat (10) tick();
    check("pre-reset count", 64'(lane_g[0].fifo_count), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rst busy", 64'(lane_g[0].busy), 64'd0);
    check("rst data_pins", 64'(lane_g[0].data_pins), 64'd0);
    check("rst valid", 64'(lane_g[0].valid_pin), 64'd0);
    check("rst count", 64'(lane_g[0].fifo_count), 64'd0);
    check("rst busy32", 64'(lane_g[1].busy), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    f = ramp(1, 0);
    for (int k = 0; k < FB; k++) f[k] = f[k] ^ 8'hC0;
    push_flit(f);
    l0_8 = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      l0_8 = {lane_g[0].data_pins[0], l0_8[7:1]};
    end
    check("post-reset lane0", 64'(l0_8), 64'hC0);
    wait_idle();

    // Simultaneous push and pop at count 2, then wrap the pointers.
    tx_en = 1'b0;
    push_flit(ramp(3, 100));
    push_flit(ramp(3, 150));
    tx_en = 1'b1;
    push_flit(ramp(3, 200));
    check("pushpop count16", 64'(lane_g[0].fifo_count), 64'd2);
    check("pushpop count32", 64'(lane_g[1].fifo_count), 64'd2);
    for (int c = 0; c < 8; c++) begin
      push_flit(ramp(9, 20 * c + 5));
      repeat (6) tick();
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
